// File: rtl/gen3_tx_frame_scheduler.sv
// Gen3 128b/130b transmit framing scheduler for a single byte-wide lane.
// Arbitrates TLP/DLLP requesters, frames packets, pads with IDL and inserts EDS + SKP blocks.
module gen3_tx_frame_scheduler #(
  parameter int SKP_INTERVAL   = 370,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_ready,
  input  logic       tlp_req,
  input  logic [9:0] tlp_len_dw,
  input  logic [7:0] tlp_data,
  input  logic       tlp_nullify,
  output logic       tlp_gnt,
  output logic       tlp_rd,
  input  logic       dllp_req,
  input  logic [7:0] dllp_data,
  output logic       dllp_gnt,
  output logic       dllp_rd,
  output logic [7:0] data_out,
  output logic       out_valid,
  output logic [1:0] sync_header,
  output logic       block_start
);

  typedef enum logic [3:0] {
    IDLE, PAD, SKP_OS, STP_TOK, TLP_PAY, TLP_END, SDP_TOK, DLLP_PAY, DLLP_END
  } state_t;

  localparam logic [11:0] SKP_LIM   = 12'(SKP_INTERVAL);
  localparam logic [3:0]  BURST_LIM = 4'(MAX_DLLP_BURST);

  state_t      state_reg, state_next;
  logic [3:0]  byte_idx_reg;
  logic [11:0] block_cnt_reg;
  logic [3:0]  burst_cnt_reg, burst_cnt_next;
  logic        skp_pending_reg;
  logic [9:0]  len_reg, len_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [7:0]  byte_next;
  logic        tlp_gnt_c, tlp_rd_c, dllp_gnt_c, dllp_rd_c;
  logic        aligned;
  logic        advance;
  logic [9:0]  len_eff;

  assign advance = rst & tx_ready;
  assign aligned = (byte_idx_reg[1:0] == 2'b00);
  // A zero-length request is framed and paid out as a single DW.
  assign len_eff = (tlp_len_dw == 10'd0) ? 10'd1 : tlp_len_dw;

  assign tlp_gnt  = tlp_gnt_c  & advance;
  assign tlp_rd   = tlp_rd_c   & advance;
  assign dllp_gnt = dllp_gnt_c & advance;
  assign dllp_rd  = dllp_rd_c  & advance;

  // IDL up to byte 12, then the EDS token occupies the last DW of the block.
  function automatic logic [7:0] pad_byte(input logic [3:0] idx);
    case (idx)
      4'd12:   pad_byte = 8'h1F;
      4'd13:   pad_byte = 8'h80;
      4'd14:   pad_byte = 8'h90;
      default: pad_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] skp_byte(input logic [3:0] idx);
    if (idx < 4'd12)       skp_byte = 8'hAA;
    else if (idx == 4'd12) skp_byte = 8'hE1;
    else                   skp_byte = 8'h00;
  endfunction

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    len_next       = len_reg;
    cnt_next       = cnt_reg;
    byte_next      = 8'h00;
    tlp_gnt_c      = 1'b0;
    tlp_rd_c       = 1'b0;
    dllp_gnt_c     = 1'b0;
    dllp_rd_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (aligned) begin
          if (!tlp_req) burst_cnt_next = 4'd0;
          if (skp_pending_reg) begin
            state_next = PAD;
            byte_next  = pad_byte(byte_idx_reg);
          end else if (dllp_req && !(tlp_req && burst_cnt_reg == BURST_LIM)) begin
            dllp_gnt_c = 1'b1;
            byte_next  = 8'hF0;
            state_next = SDP_TOK;
            if (tlp_req) burst_cnt_next = burst_cnt_reg + 4'd1;
          end else if (tlp_req) begin
            tlp_gnt_c      = 1'b1;
            byte_next      = {len_eff[3:0], 4'hF};
            len_next       = len_eff;
            cnt_next       = 12'd1;
            burst_cnt_next = 4'd0;
            state_next     = STP_TOK;
          end
        end
      end
      PAD: begin
        byte_next = pad_byte(byte_idx_reg);
        if (byte_idx_reg == 4'd15) state_next = SKP_OS;
      end
      SKP_OS: begin
        byte_next = skp_byte(byte_idx_reg);
        if (byte_idx_reg == 4'd15) state_next = IDLE;
      end
      STP_TOK: begin
        byte_next = (cnt_reg == 12'd1) ? {2'b00, len_reg[9:4]} : 8'h00;
        if (cnt_reg == 12'd3) begin
          cnt_next   = {len_reg, 2'b00} - 12'd1;
          state_next = TLP_PAY;
        end else begin
          cnt_next = cnt_reg + 12'd1;
        end
      end
      TLP_PAY: begin
        tlp_rd_c  = 1'b1;
        byte_next = tlp_data;
        if (cnt_reg == 12'd0) state_next = TLP_END;
        else                  cnt_next = cnt_reg - 12'd1;
      end
      TLP_END: begin
        byte_next  = tlp_nullify ? 8'hC0 : 8'h00;
        state_next = IDLE;
      end
      SDP_TOK: begin
        byte_next  = 8'h53;
        cnt_next   = 12'd0;
        state_next = DLLP_PAY;
      end
      DLLP_PAY: begin
        dllp_rd_c = 1'b1;
        byte_next = dllp_data;
        if (cnt_reg == 12'd7) state_next = DLLP_END;
        else                  cnt_next = cnt_reg + 12'd1;
      end
      DLLP_END: begin
        byte_next  = 8'h00;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      byte_idx_reg    <= 4'd0;
      block_cnt_reg   <= 12'd0;
      burst_cnt_reg   <= 4'd0;
      skp_pending_reg <= 1'b0;
      len_reg         <= 10'd0;
      cnt_reg         <= 12'd0;
      data_out        <= 8'h00;
      out_valid       <= 1'b0;
      sync_header     <= 2'b01;
      block_start     <= 1'b0;
    end else begin
      out_valid <= 1'b1;
      if (tx_ready) begin
        state_reg     <= state_next;
        burst_cnt_reg <= burst_cnt_next;
        len_reg       <= len_next;
        cnt_reg       <= cnt_next;
        byte_idx_reg  <= byte_idx_reg + 4'd1;
        data_out      <= byte_next;
        block_start   <= (byte_idx_reg == 4'd0);
        if (byte_idx_reg == 4'd0)
          sync_header <= (state_reg == SKP_OS) ? 2'b10 : 2'b01;
        // SKP blocks end the pending request but never count as data blocks.
        if (byte_idx_reg == 4'd15) begin
          if (state_reg == SKP_OS) begin
            skp_pending_reg <= 1'b0;
          end else if (block_cnt_reg + 12'd1 == SKP_LIM) begin
            block_cnt_reg   <= 12'd0;
            skp_pending_reg <= 1'b1;
          end else begin
            block_cnt_reg <= block_cnt_reg + 12'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gen3_tx_frame_scheduler.sv
// Randomized bench for gen3_tx_frame_scheduler: a queue-based byte-stream model predicts
// every accepted output byte and handshake strobe.
module tb_gen3_tx_frame_scheduler;

  localparam int SKP_I = 4;
  localparam int MAXB  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_ready = 1'b1;
  logic       tlp_req = 1'b0;
  logic [9:0] tlp_len_dw = '0;
  logic [7:0] tlp_data = '0;
  logic       tlp_nullify = 1'b0;
  logic       dllp_req = 1'b0;
  logic [7:0] dllp_data = '0;
  logic       tlp_gnt, tlp_rd, dllp_gnt, dllp_rd;
  logic [7:0] data_out;
  logic       out_valid, block_start;
  logic [1:0] sync_header;

  gen3_tx_frame_scheduler #(.SKP_INTERVAL(SKP_I), .MAX_DLLP_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .tx_ready(tx_ready),
    .tlp_req(tlp_req), .tlp_len_dw(tlp_len_dw), .tlp_data(tlp_data),
    .tlp_nullify(tlp_nullify), .tlp_gnt(tlp_gnt), .tlp_rd(tlp_rd),
    .dllp_req(dllp_req), .dllp_data(dllp_data), .dllp_gnt(dllp_gnt), .dllp_rd(dllp_rd),
    .data_out(data_out), .out_valid(out_valid), .sync_header(sync_header),
    .block_start(block_start)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mism = 0;
  int cyc = 0;

  logic [7:0] t_stream [8192];
  logic [7:0] d_stream [256];

  // requester-side stimulus state
  int t_pending = 0, d_pending = 0;
  int t_gcnt = 0, t_cur = 0, t_k = 0;
  int d_gcnt = 0, d_cur = 0, d_k = 0;

  // reference model: queue of bytes still owed by the current frame/segment
  typedef struct packed {
    logic [7:0] b;
    logic       skp;
    logic       trd;
    logic       drd;
  } ent_t;
  ent_t mq[$];
  int   m_idx = 0, m_blk = 0, m_burst = 0, m_tn = 0, m_dn = 0;
  bit   m_skp = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_bs = 1'b0, m_val = 1'b0;
  logic [1:0] m_sync = 2'b01;

  logic [3:0]  a_stb, e_stb;
  logic [15:0] act_vec, exp_vec;

  task automatic m_push(input logic [7:0] b, input logic s, input logic t, input logic d);
    ent_t e;
    e.b = b; e.skp = s; e.trd = t; e.drd = d;
    mq.push_back(e);
  endtask

  // Predicts one clock edge: returns expected {tlp_gnt, tlp_rd, dllp_gnt, dllp_rd}.
  task automatic m_step(output logic [3:0] stb);
    ent_t e;
    logic [9:0] len;
    stb = 4'b0000;
    if (!rst) begin
      mq.delete();
      m_idx = 0; m_blk = 0; m_burst = 0; m_skp = 0;
      m_data = 8'h00; m_bs = 1'b0; m_sync = 2'b01; m_val = 1'b0;
      return;
    end
    m_val = 1'b1;
    if (!tx_ready) return;
    if (mq.size() == 0) begin
      if (m_idx % 4 == 0) begin
        if (!tlp_req) m_burst = 0;
        if (m_skp) begin
          for (int i = m_idx; i < 12; i++) m_push(8'h00, 0, 0, 0);
          m_push(8'h1F, 0, 0, 0); m_push(8'h80, 0, 0, 0);
          m_push(8'h90, 0, 0, 0); m_push(8'h00, 0, 0, 0);
          for (int i = 0; i < 16; i++)
            m_push(i < 12 ? 8'hAA : (i == 12 ? 8'hE1 : 8'h00), 1, 0, 0);
        end else if (dllp_req && !(tlp_req && m_burst == MAXB)) begin
          stb[1] = 1'b1;
          if (tlp_req) m_burst++;
          m_push(8'hF0, 0, 0, 0); m_push(8'h53, 0, 0, 0);
          for (int k = 0; k < 8; k++) m_push(d_stream[(m_dn * 8 + k) & 255], 0, 0, 1);
          m_push(8'h00, 0, 0, 0);
          m_dn++;
        end else if (tlp_req) begin
          stb[3] = 1'b1;
          m_burst = 0;
          len = (tlp_len_dw == 10'd0) ? 10'd1 : tlp_len_dw;
          m_push({len[3:0], 4'hF}, 0, 0, 0);
          m_push({2'b00, len[9:4]}, 0, 0, 0);
          m_push(8'h00, 0, 0, 0); m_push(8'h00, 0, 0, 0);
          for (int k = 0; k < int'(len) * 4; k++) m_push(t_stream[(m_tn * 131 + k) & 8191], 0, 1, 0);
          m_push(tlp_nullify ? 8'hC0 : 8'h00, 0, 0, 0);
          m_tn++;
        end else begin
          m_push(8'h00, 0, 0, 0);
        end
      end else begin
        m_push(8'h00, 0, 0, 0);
      end
    end
    e = mq.pop_front();
    stb[2] = e.trd;
    stb[0] = e.drd;
    m_data = e.b;
    m_bs   = (m_idx == 0);
    if (m_idx == 0) m_sync = e.skp ? 2'b10 : 2'b01;
    if (m_idx == 15) begin
      if (e.skp) m_skp = 0;
      else begin
        m_blk++;
        if (m_blk == SKP_I) begin m_blk = 0; m_skp = 1; end
      end
    end
    m_idx = (m_idx + 1) % 16;
  endtask

  // One clock: drive requesters, predict, clock, respond to handshakes, sample outputs.
  task automatic cycle();
    @(negedge clk);
    tlp_req   = (t_pending > 0);
    dllp_req  = (d_pending > 0);
    tlp_data  = t_stream[(t_cur * 131 + t_k) & 8191];
    dllp_data = d_stream[(d_cur * 8 + d_k) & 255];
    #1;
    a_stb = {tlp_gnt, tlp_rd, dllp_gnt, dllp_rd};
    m_step(e_stb);
    @(posedge clk);
    if (a_stb[3]) begin t_cur = t_gcnt; t_gcnt++; t_k = 0; if (t_pending > 0) t_pending--; end
    if (a_stb[2]) t_k++;
    if (a_stb[1]) begin d_cur = d_gcnt; d_gcnt++; d_k = 0; if (d_pending > 0) d_pending--; end
    if (a_stb[0]) d_k++;
    #1;
    act_vec = {out_valid, block_start, (m_bs ? sync_header : 2'b00), data_out, a_stb};
    exp_vec = {m_val, m_bs, (m_bs ? m_sync : 2'b00), m_data, e_stb};
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      cycle();
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL reset_vec cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
      if ({data_out, out_valid, block_start, sync_header} !== {8'h00, 1'b0, 1'b0, 2'b01}) begin
        mism++;
        $display("FAIL reset_outs cyc %0d: got %h/%b/%b/%b expected 00/0/0/01",
                 cyc, data_out, out_valid, block_start, sync_header);
      end
      compared++;
    end
    rst = 1'b1;
  endtask

  task automatic test_idle_skp();
    int skp_seen = 0;
    repeat (16 * 14) begin
      cycle();
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL idle_skp cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
      if (block_start === 1'b1 && sync_header === 2'b10) skp_seen++;
    end
    if (skp_seen < 2) begin
      mism++; $display("FAIL idle_skp_count: got %0d ordered-set blocks required >= 2", skp_seen);
    end
    compared++;
  endtask

  task automatic test_tlp();
    int lens [8];
    bit nul [8];
    lens[0] = 3; nul[0] = 0;
    lens[1] = 3; nul[1] = 1;
    for (int i = 2; i < 8; i++) begin
      lens[i] = (i == 2) ? 0 : int'($urandom_range(1, 24));
      nul[i]  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) begin
      tlp_len_dw  = 10'(lens[i]);
      tlp_nullify = nul[i];
      t_pending   = 1;
      repeat (lens[i] * 4 + 70) begin
        cycle();
        if (act_vec !== exp_vec) begin
          mism++; $display("FAIL tlp len=%0d cyc %0d: got %h expected %h", lens[i], cyc, act_vec, exp_vec);
        end
        compared++;
      end
      if (t_pending !== 0) begin
        mism++; $display("FAIL tlp_granted len=%0d: got pending %0d required 0", lens[i], t_pending);
      end
      compared++;
    end
  endtask

  task automatic test_long_tlp();
    int rd_cnt = 0;
    tlp_len_dw  = 10'h2A5;
    tlp_nullify = 1'b0;
    t_pending   = 1;
    repeat (2708 + 110) begin
      cycle();
      if (a_stb[2] === 1'b1) rd_cnt++;
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL long_tlp cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
    end
    if (rd_cnt !== 2708) begin
      mism++; $display("FAIL long_tlp_rd_count: got %0d required 2708", rd_cnt);
    end
    compared++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] order = '0;
    tlp_len_dw  = 10'd2;
    tlp_nullify = 1'b0;
    d_pending   = 3;
    t_pending   = 1;
    repeat (160) begin
      cycle();
      if (a_stb[1] === 1'b1) order = {order[23:0], "D"};
      if (a_stb[3] === 1'b1) order = {order[23:0], "T"};
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL arb cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
    end
    if (order !== "DDTD") begin
      mism++; $display("FAIL arb_order: got %s required DDTD", order);
    end
    compared++;
    for (int r = 0; r < 5; r++) begin
      tlp_len_dw  = 10'($urandom_range(0, 6));
      tlp_nullify = 1'($urandom_range(0, 1));
      d_pending   = int'($urandom_range(0, 4));
      t_pending   = int'($urandom_range(0, 2));
      repeat (220) begin
        cycle();
        if (act_vec !== exp_vec) begin
          mism++; $display("FAIL arb_rand r=%0d cyc %0d: got %h expected %h", r, cyc, act_vec, exp_vec);
        end
        compared++;
      end
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < 2; r++) begin
      tlp_len_dw  = 10'(5 + r * 3);
      tlp_nullify = 1'(r);
      t_pending   = 1;
      d_pending   = r;
      repeat (220) begin
        tx_ready = ($urandom_range(0, 2) != 0);
        cycle();
        if (act_vec !== exp_vec) begin
          mism++; $display("FAIL stall cyc %0d rdy=%b: got %h expected %h", cyc, tx_ready, act_vec, exp_vec);
        end
        compared++;
      end
      tx_ready = 1'b1;
      repeat (40) begin
        cycle();
        if (act_vec !== exp_vec) begin
          mism++; $display("FAIL stall_drain cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
        end
        compared++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int rd_seen = 0;
    int budget = 0;
    tlp_len_dw  = 10'd20;
    tlp_nullify = 1'b1;
    t_pending   = 1;
    while (rd_seen < 10 && budget < 200) begin
      cycle();
      budget++;
      if (a_stb[2] === 1'b1) rd_seen++;
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL rstmid_pre cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
    end
    if (rd_seen < 10) begin
      mism++; $display("FAIL rstmid_payload_timeout: got %0d reads required 10", rd_seen);
    end
    compared++;
    rst = 1'b0;
    cycle();
    if ({out_valid, data_out, a_stb} !== {1'b0, 8'h00, 4'b0000}) begin
      mism++;
      $display("FAIL rstmid_reset: got valid=%b data=%h strobes=%b required 0/00/0000",
               out_valid, data_out, a_stb);
    end
    compared++;
    rst = 1'b1;
    repeat (80) begin
      cycle();
      if (act_vec !== exp_vec) begin
        mism++; $display("FAIL rstmid_post cyc %0d: got %h expected %h", cyc, act_vec, exp_vec);
      end
      compared++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) t_stream[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)  d_stream[i] = 8'($urandom);
    test_reset();
    test_idle_skp();
    test_tlp();
    test_long_tlp();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/gen3_tx_frame_scheduler.md
Name: gen3_tx_frame_scheduler

Overview:
Transmit-side Gen3 (128b/130b) framing scheduler for one lane, one byte per cycle. It arbitrates between a TLP requester and a DLLP requester and wraps each packet in framing tokens: STP for TLPs, SDP for DLLPs. It fills gaps with IDL and emits 16-byte blocks with sync headers. It periodically schedules an EDS token followed by a SKP ordered-set block. Its output stream is exactly what the receive-side Gen3 byte checker decodes.

Parameters:
SKP_INTERVAL, 370, data blocks between SKP ordered sets (legal 2..4095)
MAX_DLLP_BURST, 4, consecutive DLLPs granted while a TLP waits before the TLP must win (1..15)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
tx_ready  in  1  downstream accepts the current output byte at this edge
tlp_req  in  1  TLP pending; held until tlp_gnt
tlp_len_dw  in  10  TLP payload length in DW; sampled at grant
tlp_data  in  8  current TLP payload byte (first-word-fall-through)
tlp_nullify  in  1  sampled at trailer byte; 1 selects EDB marker
tlp_gnt  out  1  1-cycle pulse on the accepted edge carrying STP byte0
tlp_rd  out  1  payload byte consumed at this edge
dllp_req  in  1  DLLP pending; held until dllp_gnt
dllp_data  in  8  current DLLP byte
dllp_gnt  out  1  1-cycle pulse on the accepted edge carrying SDP byte0
dllp_rd  out  1  DLLP byte consumed at this edge
data_out  out  8  registered output byte
out_valid  out  1  0 in reset, 1 from the first cycle after reset release
sync_header  out  2  2'b01 data block, 2'b10 ordered-set block; meaningful when block_start=1
block_start  out  1  data_out is byte 0 of a block

Behaviour:
- Reset (rst=0 at edge): state IDLE, byte_idx=0, block_cnt=0, burst_cnt=0, skp_pending=0. Outputs: data_out=0x00, out_valid=0, sync_header=2'b01, block_start=0. tlp_gnt, tlp_rd, dllp_gnt and dllp_rd are 0. Reset mid-packet abandons the packet; no trailer is sent.
- Advance: all state and output registers update only on edges where tx_ready=1. With tx_ready=0 everything holds.
- tlp_rd and dllp_rd are combinational and are only asserted together with tx_ready=1. Consumed byte appears on data_out the following cycle (latency 1).
- byte_idx counts 0..15 per accepted byte. block_start=1 when the emitted byte has byte_idx=0.
- block_cnt increments at the end of each data block. When it reaches SKP_INTERVAL, skp_pending is set and block_cnt clears.
- Decision point: state IDLE and byte_idx[1:0]==0 (DW-aligned). Priority order:
  1. skp_pending: go to PAD, emitting IDL 0x00 until byte_idx==12; then EDS bytes 0x1F,0x80,0x90,0x00 at idx 12..15; then SKP_OS.
  2. dllp_req, unless a TLP is waiting and burst_cnt==MAX_DLLP_BURST.
  3. tlp_req.
  4. Otherwise emit IDL 0x00.
  At a non-aligned position in IDLE, always emit IDL.
- burst_cnt: increments on each dllp_gnt while tlp_req=1. Clears on tlp_gnt, or when tlp_req=0 at a decision point.
- STP_TOK (4 bytes):
  - byte0 = {len[3:0],4'hF}, byte1 = {2'b00,len[9:4]}, byte2 = 0x00, byte3 = 0x00.
  - len = tlp_len_dw latched at grant; tlp_len_dw==0 is transmitted and counted as 1.
- TLP_PAY: len*4 bytes taken from tlp_data, one per accepted edge.
- TLP_END: 1 trailer byte, 0xC0 if tlp_nullify=1, else 0x00. Then IDLE.
- SDP_TOK: 0xF0, 0x53. DLLP_PAY: 8 bytes from dllp_data. DLLP_END: 0x00. Then IDLE.
- Packets may straddle block boundaries. A new block always carries sync 2'b01 while in any data-stream state.
- SKP_OS: 16 bytes, sync_header=2'b10: 0xAA at idx 0..11, 0xE1 at idx 12, 0x00 at idx 13..15. Then clear skp_pending and return to IDLE. SKP blocks do not count toward block_cnt.
- Simultaneous events:
  - skp_pending set during a packet waits for the packet trailer.
  - tlp_req and dllp_req together resolve per the priority rules above.
- Pending requests are not granted during PAD, EDS or SKP_OS.

Test Plan:
- Reset release, no requests, SKP_INTERVAL=4 -> out_valid=1; all bytes 0x00; block_start every 16 accepted bytes with sync 01. After block 4: IDL idx 0..11, EDS 1F 80 90 00 at idx 12..15, then SKP block (sync 10) AA×12 E1 00 00 00.
- tlp_req with len=3 at idx 0 -> STP 3F 00 00 00; tlp_gnt pulse on byte0; 12 payload bytes with 12 tlp_rd pulses; trailer 0x00. Repeat with tlp_nullify=1 -> trailer 0xC0.
- tlp_req len=0x2A5 -> byte0 0x5F, byte1 0x2A; 2708 payload bytes; packet crosses blocks with sync 01 at each block_start.
- dllp_req and tlp_req held together, MAX_DLLP_BURST=2 -> DLLP, DLLP, TLP grant order. Each DLLP is F0 53 + 8 bytes + 00.
- tx_ready toggled 0/1 during a TLP payload -> data_out/state frozen while 0; no tlp_rd while 0; byte sequence identical to the unstalled run.
- rst=0 mid-TLP payload -> next cycle out_valid=0, data_out=0x00, all strobes 0. After release: block_cnt=0, byte_idx=0, IDL stream.
